dmem_responder: RTL and testbench

- Data-side memory responder for the single-cycle RISC-V core. It answers the core's data port: address, write data and MemWrite in; ReadData out.
- Contains a word-addressed RAM and a small MMIO register block: GPIO output, free-running timer with compare flag, sticky status, and a byte TX FIFO drained over a valid/ready handshake.
- Reads are combinational, which the single-cycle core requires. Writes commit on the rising clock edge.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_responder_tx_fifo.sv | 85 ++++++++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the MMIO register map, STATUS bit positions, the address bit that
// selects the MMIO region and the address-region type used by the decoder.

package dmem_pkg;

   // Address bit that separates RAM (0) from MMIO (1)
   localparam int MMIO_SEL_BIT = 31;

   // MMIO byte offsets; only DataAdr[4:2] take part in the decode
   localparam logic [4:0] GPIO_OFS   = 5'h00;
   localparam logic [4:0] TCOUNT_OFS = 5'h04;
   localparam logic [4:0] TCMP_OFS   = 5'h08;
   localparam logic [4:0] STATUS_OFS = 5'h0C;
   localparam logic [4:0] TXDATA_OFS = 5'h10;

   // STATUS bit positions: bits 0..2 are sticky (W1C), bits 3..4 are live
   localparam int ST_TIMER_MATCH = 0;
   localparam int ST_ADDR_ERR    = 1;
   localparam int ST_TX_OVF      = 2;
   localparam int ST_FIFO_FULL   = 3;
   localparam int ST_FIFO_EMPTY  = 4;
   localparam int STICKY_BITS    = 3;

   localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

   // Where an address lands after decode
   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_ERR
   } region_e;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: byte FIFO feeding the downstream TX valid/ready interface.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low; flushes the FIFO
//   push       write push_data this edge (honoured when not full, or when
//              a pop happens on the same edge)
//   push_data  byte to enqueue
//   pop        dequeue the head this edge (ignored while empty)
//   head       oldest byte, 0 while empty
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   count      occupancy, 0..DEPTH

module tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       buf_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign head  = empty ? 8'h00 : buf_q[rd_ptr_q];

   // A pop frees a slot on the same edge, so a push into a full FIFO is
   // still accepted when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: empty already masks the head
   always_ff @(posedge clk) begin
      if (do_push) begin
         buf_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder for the single-cycle RISC-V core.
// Word-addressed RAM below 0x8000_0000, MMIO registers above it
// (GPIO, free-running timer + compare, STATUS, TX byte FIFO).
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-low
//   DataAdr    byte address from the core (bits 1:0 ignored)
//   WriteData  store data
//   MemWrite   store strobe, sampled at the rising edge
//   ReadData   combinational load data
//   gpio_out   GPIO register
//   timer_irq  STATUS[0]
//   tx_data    FIFO head byte, 0 when empty
//   tx_valid   FIFO non-empty
//   tx_ready   downstream accepts the head when high together with tx_valid

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int RAM_WORDS = 64,
   parameter int TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic [7:0]  gpio_out,
   output logic        timer_irq,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_IDX_W = $clog2(RAM_WORDS);
   localparam int CNT_W     = $clog2(TX_DEPTH) + 1;

   logic [31:0]            ram [RAM_WORDS];

   logic [7:0]             gpio_q, gpio_d;
   logic [31:0]            tcount_q, tcount_d;
   logic [31:0]            tcmp_q, tcmp_d;
   logic [STICKY_BITS-1:0] sticky_q, sticky_d;
   logic [STICKY_BITS-1:0] sticky_set;
   logic [STICKY_BITS-1:0] sticky_clr;

   logic [28:0]            word_idx;
   logic [RAM_IDX_W-1:0]   ram_idx;
   logic [4:0]             mmio_ofs;
   region_e                region;
   logic                   mmio_wr;
   logic [31:0]            status_word;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic [7:0]             fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;

   // Word access only: the byte-lane bits never matter
   logic unused_adr_bits;
   assign unused_adr_bits = ^DataAdr[1:0];

   assign word_idx = DataAdr[30:2];
   assign ram_idx  = word_idx[RAM_IDX_W-1:0];
   assign mmio_ofs = {DataAdr[4:2], 2'b00};

   // The core presents DataAdr every cycle with no read strobe, so any
   // edge on which the address decodes to nothing flags an address error.
   always_comb begin
      region = REGION_ERR;
      if (DataAdr[MMIO_SEL_BIT]) begin
         if (mmio_ofs <= TXDATA_OFS) begin
            region = REGION_MMIO;
         end
      end else if (word_idx < 29'(RAM_WORDS)) begin
         region = REGION_RAM;
      end
   end

   assign mmio_wr = MemWrite && (region == REGION_MMIO);

   always_comb begin
      status_word                = '0;
      status_word[STICKY_BITS-1:0] = sticky_q;
      status_word[ST_FIFO_FULL]  = fifo_full;
      status_word[ST_FIFO_EMPTY] = fifo_empty;
   end

   always_comb begin
      ReadData = '0;
      case (region)
         REGION_RAM: ReadData = ram[ram_idx];
         REGION_MMIO: begin
            case (mmio_ofs)
               GPIO_OFS:   ReadData = {24'h0, gpio_q};
               TCOUNT_OFS: ReadData = tcount_q;
               TCMP_OFS:   ReadData = tcmp_q;
               STATUS_OFS: ReadData = status_word;
               TXDATA_OFS: ReadData = 32'(fifo_count);
               default:    ReadData = '0;
            endcase
         end
         default: ReadData = '0;
      endcase
   end

   assign fifo_push = mmio_wr && (mmio_ofs == TXDATA_OFS);
   assign fifo_pop  = !fifo_empty && tx_ready;

   // Sticky bits: a set on the same edge as a W1C wins over the clear
   always_comb begin
      gpio_d     = gpio_q;
      tcmp_d     = tcmp_q;
      tcount_d   = tcount_q + 32'd1;
      sticky_set = '0;
      sticky_clr = '0;

      if (mmio_wr) begin
         case (mmio_ofs)
            GPIO_OFS:   gpio_d     = WriteData[7:0];
            TCOUNT_OFS: tcount_d   = '0;
            TCMP_OFS:   tcmp_d     = WriteData;
            STATUS_OFS: sticky_clr = WriteData[STICKY_BITS-1:0];
            default:    ;
         endcase
      end

      sticky_set[ST_TIMER_MATCH] = (tcount_q == tcmp_q);
      sticky_set[ST_ADDR_ERR]    = (region == REGION_ERR);
      sticky_set[ST_TX_OVF]      = fifo_push && fifo_full && !fifo_pop;

      sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_q   <= '0;
         tcount_q <= '0;
         tcmp_q   <= TCMP_RESET;
         sticky_q <= '0;
      end else begin
         gpio_q   <= gpio_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         sticky_q <= sticky_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (MemWrite && (region == REGION_RAM)) begin
         ram[ram_idx] <= WriteData;
      end
   end

   tx_fifo #(
      .DEPTH(TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (WriteData[7:0]),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign gpio_out  = gpio_q;
   assign timer_irq = sticky_q[ST_TIMER_MATCH];
   assign tx_data   = fifo_head;
   assign tx_valid  = !fifo_empty;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM/MMIO decode, timer compare,
// STATUS W1C, TX FIFO ordering/overflow and asynchronous reset.

module tb_dmem_responder;

   localparam int RAM_WORDS = 64;
   localparam int TX_DEPTH  = 4;

   localparam logic [31:0] GPIO_ADR   = 32'h8000_0000;
   localparam logic [31:0] TCOUNT_ADR = 32'h8000_0004;
   localparam logic [31:0] TCMP_ADR   = 32'h8000_0008;
   localparam logic [31:0] STATUS_ADR = 32'h8000_000C;
   localparam logic [31:0] TXDATA_ADR = 32'h8000_0010;
   localparam logic [31:0] HOLE_ADR   = 32'h8000_0018;

   logic        clk;
   logic        reset;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic [7:0]  gpio_out;
   logic        timer_irq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int checks   = 0;
   int failures = 0;

   // Scoreboard of bytes the FIFO is expected to emit, oldest first
   logic [7:0] expQueue[$];

   dmem_responder #(
      .RAM_WORDS (RAM_WORDS),
      .TX_DEPTH  (TX_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one core cycle, checks the TX side against the scoreboard just
   // before the edge, predicts FIFO acceptance, then returns 1 unit after it
   task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] wdata,
                                input logic we);
      logic [7:0] expByte;
      DataAdr   = adr;
      WriteData = wdata;
      MemWrite  = we;
      checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, (expQueue.size() != 0)});
      if (tx_ready && expQueue.size() > 0) begin
         expByte = expQueue.pop_front();
         checkOutput("tx_order", {24'b0, tx_data}, {24'b0, expByte});
      end
      if (we && adr == TXDATA_ADR && expQueue.size() < TX_DEPTH) begin
         expQueue.push_back(wdata[7:0]);
      end
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
   endtask

   // Combinational load, no clock edge involved
   task automatic readCheck(input string tag, input logic [31:0] adr,
                            input logic [31:0] expected);
      DataAdr = adr;
      #1;
      checkOutput(tag, ReadData, expected);
      DataAdr = '0;
   endtask

   initial begin
      reset     = 1'b1;
      DataAdr   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
      tx_ready  = 1'b0;
      #1;
      reset = 1'b0;
      #1;

      // Reset state
      checkOutput("rst_gpio", {24'b0, gpio_out}, 32'h0);
      checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h0);
      checkOutput("rst_irq", {31'b0, timer_irq}, 32'h0);
      readCheck("rst_tcmp", TCMP_ADR, 32'hFFFF_FFFF);
      readCheck("rst_tcount", TCOUNT_ADR, 32'h0);
      @(posedge clk);
      #1;
      readCheck("rst_status", STATUS_ADR, 32'h10);
      readCheck("rst_tcount_held", TCOUNT_ADR, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // RAM store/load, byte-offset aliasing, last word, misses
      applyStimulus(32'h10, 32'hDEAD_BEEF, 1'b1);
      readCheck("ram_load_0x10", 32'h10, 32'hDEAD_BEEF);
      readCheck("ram_load_0x13", 32'h13, 32'hDEAD_BEEF);
      applyStimulus(32'h0, 32'h1111_1111, 1'b1);
      applyStimulus(32'hFC, 32'hCAFE_F00D, 1'b1);
      readCheck("ram_last_word", 32'hFC, 32'hCAFE_F00D);
      readCheck("ram_miss_read", 32'h400, 32'h0);
      readCheck("status_no_err", STATUS_ADR, 32'h10);
      applyStimulus(32'h400, 32'h0, 1'b0);
      readCheck("status_err_on_load", STATUS_ADR, 32'h12);
      applyStimulus(STATUS_ADR, 32'h2, 1'b1);
      readCheck("status_w1c_err", STATUS_ADR, 32'h10);
      applyStimulus(32'h100, 32'hBAD0_BAD0, 1'b1);
      readCheck("ram_miss_no_alias", 32'h0, 32'h1111_1111);
      readCheck("status_err_on_store", STATUS_ADR, 32'h12);
      applyStimulus(STATUS_ADR, 32'h2, 1'b1);
      readCheck("mmio_hole_read", HOLE_ADR, 32'h0);
      applyStimulus(HOLE_ADR, 32'hFF, 1'b1);
      readCheck("status_err_hole", STATUS_ADR, 32'h12);
      applyStimulus(STATUS_ADR, 32'h2, 1'b1);
      readCheck("status_w1c_err2", STATUS_ADR, 32'h10);

      // Timer compare, W1C, TCOUNT clear, set-wins-over-clear
      applyStimulus(TCMP_ADR, 32'd5, 1'b1);
      readCheck("tcmp_rw", TCMP_ADR, 32'd5);
      applyStimulus(TCOUNT_ADR, 32'h0, 1'b1);
      readCheck("tcount_cleared", TCOUNT_ADR, 32'd0);
      repeat (5) applyStimulus(32'h0, 32'h0, 1'b0);
      readCheck("tcount_at_cmp", TCOUNT_ADR, 32'd5);
      checkOutput("irq_before_match", {31'b0, timer_irq}, 32'h0);
      applyStimulus(32'h0, 32'h0, 1'b0);
      checkOutput("irq_on_match", {31'b0, timer_irq}, 32'h1);
      readCheck("status_match", STATUS_ADR, 32'h11);
      applyStimulus(STATUS_ADR, 32'h1, 1'b1);
      checkOutput("irq_w1c", {31'b0, timer_irq}, 32'h0);
      repeat (3) applyStimulus(32'h0, 32'h0, 1'b0);
      readCheck("tcount_running", TCOUNT_ADR, 32'd10);
      applyStimulus(TCOUNT_ADR, 32'h1234, 1'b1);
      readCheck("tcount_write_zero", TCOUNT_ADR, 32'd0);
      applyStimulus(32'h0, 32'h0, 1'b0);
      readCheck("tcount_restart", TCOUNT_ADR, 32'd1);
      repeat (4) applyStimulus(32'h0, 32'h0, 1'b0);
      applyStimulus(STATUS_ADR, 32'h1, 1'b1);
      checkOutput("irq_set_wins", {31'b0, timer_irq}, 32'h1);
      applyStimulus(STATUS_ADR, 32'h1, 1'b1);
      checkOutput("irq_cleared", {31'b0, timer_irq}, 32'h0);

      // TX FIFO ordering
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(TXDATA_ADR, 32'hABCD_EF41 + i, 1'b1);
      end
      readCheck("tx_occupancy3", TXDATA_ADR, 32'd3);
      checkOutput("tx_head", {24'b0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      repeat (3) applyStimulus(32'h0, 32'h0, 1'b0);
      tx_ready = 1'b0;
      checkOutput("tx_drained_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("tx_drained_data", {24'b0, tx_data}, 32'h0);
      readCheck("status_empty", STATUS_ADR, 32'h10);
      checkOutput("sb_empty1", 32'(expQueue.size()), 32'd0);

      // Overflow, then push-while-full with a simultaneous pop
      for (int i = 0; i < 5; i++) begin
         applyStimulus(TXDATA_ADR, 32'h51 + i, 1'b1);
      end
      readCheck("tx_occupancy_full", TXDATA_ADR, 32'd4);
      readCheck("status_ovf_full", STATUS_ADR, 32'h0C);
      tx_ready = 1'b1;
      applyStimulus(TXDATA_ADR, 32'h56, 1'b1);
      readCheck("tx_full_push_pop", TXDATA_ADR, 32'd4);
      readCheck("status_still_full", STATUS_ADR, 32'h0C);
      repeat (4) applyStimulus(32'h0, 32'h0, 1'b0);
      tx_ready = 1'b0;
      checkOutput("sb_empty2", 32'(expQueue.size()), 32'd0);
      applyStimulus(STATUS_ADR, 32'h4, 1'b1);
      readCheck("status_w1c_ovf", STATUS_ADR, 32'h10);

      // GPIO, then asynchronous reset mid-cycle with bytes held
      applyStimulus(GPIO_ADR, 32'h1234_56A5, 1'b1);
      checkOutput("gpio_out", {24'b0, gpio_out}, 32'hA5);
      readCheck("gpio_read", GPIO_ADR, 32'hA5);
      applyStimulus(TXDATA_ADR, 32'h61, 1'b1);
      applyStimulus(TXDATA_ADR, 32'h62, 1'b1);
      readCheck("tx_occupancy2", TXDATA_ADR, 32'd2);
      reset = 1'b0;
      #1;
      expQueue.delete();
      checkOutput("arst_gpio", {24'b0, gpio_out}, 32'h0);
      checkOutput("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("arst_tx_data", {24'b0, tx_data}, 32'h0);
      readCheck("arst_tcount", TCOUNT_ADR, 32'h0);
      readCheck("arst_tcmp", TCMP_ADR, 32'hFFFF_FFFF);
      readCheck("arst_status", STATUS_ADR, 32'h10);
      reset = 1'b1;
      applyStimulus(32'h0, 32'h0, 1'b0);
      readCheck("post_rst_tcount", TCOUNT_ADR, 32'd1);
      readCheck("post_rst_occupancy", TXDATA_ADR, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
